fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 113 +++++++++++
 tb/tb_fetch_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives a PC into instruction memory and holds one fetched word for decode.
// Optional performance counters (fetch_count, stall_count) are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        imem_ce,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        misalign,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count,
`endif
   output logic [1:0]  dbg_state
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FETCH  = 2'd1;
   localparam logic [1:0] BUBBLE = 2'd2;

   logic [1:0]  r_state;
   logic [31:0] r_pc;
   logic        r_inst_valid;
   logic [31:0] r_inst;
   logic [31:0] r_inst_pc;
   logic        r_misalign;

   logic w_redirect;
   logic w_fire;
   logic w_consume;

   // Handshakes: a fetch completes in a cycle with imem_ce && imem_ready; the decode
   // slot is held while inst_valid && stall and consumed when inst_valid && !stall.
   assign w_redirect = redirect_valid && (r_state != IDLE);
   assign imem_ce    = !rst && (r_state == FETCH) && !redirect_valid && (!r_inst_valid || !stall);
   assign w_fire     = imem_ce && imem_ready;
   assign w_consume  = r_inst_valid && !stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         case (r_state)
            IDLE:    r_state <= FETCH;
            FETCH:   r_state <= redirect_valid ? BUBBLE : FETCH;
            BUBBLE:  r_state <= redirect_valid ? BUBBLE : FETCH;
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc         <= 32'h0;
         r_inst_valid <= 1'b0;
         r_inst       <= 32'h0;
         r_inst_pc    <= 32'h0;
         r_misalign   <= 1'b0;
      end else if (w_redirect) begin
         r_pc         <= {redirect_target[31:2], 2'b00};
         r_inst_valid <= 1'b0;
         if (redirect_target[1:0] != 2'b00) begin
            r_misalign <= 1'b1;
         end
      end else if (w_fire) begin
         r_inst       <= imem_rdata;
         r_inst_pc    <= r_pc;
         r_inst_valid <= 1'b1;
         r_pc         <= r_pc + 32'd4;
      end else if (w_consume) begin
         r_inst_valid <= 1'b0;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_count;
   logic [31:0] r_stall_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_count <= 32'h0;
         r_stall_count <= 32'h0;
      end else begin
         if (w_fire) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
         if ((r_state == FETCH) && r_inst_valid && stall) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
      end
   end

   assign fetch_count = r_fetch_count;
   assign stall_count = r_stall_count;
`endif

   assign imem_addr  = r_pc;
   assign pc         = r_pc;
   assign inst_valid = r_inst_valid;
   assign inst       = r_inst;
   assign inst_pc    = r_inst_pc;
   assign misalign   = r_misalign;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl; the memory returns a fixed function of the address so expected words are known.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_ctrl;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_BUBBLE = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        imem_ce;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        misalign;
   logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_ready      (imem_ready),
      .imem_rdata      (imem_rdata),
      .imem_ce         (imem_ce),
      .imem_addr       (imem_addr),
      .pc              (pc),
      .inst_valid      (inst_valid),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .misalign        (misalign),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count     (fetch_count),
      .stall_count     (stall_count),
`endif
      .dbg_state       (dbg_state)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0; imem_ready = 1'b1;
      tick(); tick();
      n_checks++;
      if ({imem_ce, pc, inst_valid, inst, inst_pc, misalign, dbg_state} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, S_IDLE}) begin
         n_fail++;
         $display("FAIL reset_state: got ce=%b pc=%h v=%b inst=%h ipc=%h mis=%b st=%0d exp ce=0 pc=0 v=0 inst=0 ipc=0 mis=0 st=0",
                  imem_ce, pc, inst_valid, inst, inst_pc, misalign, dbg_state);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if ({imem_ce, dbg_state} !== {1'b0, S_IDLE}) begin
         n_fail++;
         $display("FAIL reset_first_cycle: got ce=%b st=%0d exp ce=0 st=0", imem_ce, dbg_state);
      end
   endtask

   task automatic test_sequential();
      tick();
      n_checks++;
      if ({dbg_state, imem_ce, imem_addr, inst_valid} !== {S_FETCH, 1'b1, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL seq_addr0: got st=%0d ce=%b addr=%h v=%b exp st=1 ce=1 addr=00000000 v=0", dbg_state, imem_ce, imem_addr, inst_valid);
      end
      tick();
      n_checks++;
      if ({imem_ce, imem_addr, inst_valid, inst_pc, inst} !== {1'b1, 32'h4, 1'b1, 32'h0, mem_word(32'h0)}) begin
         n_fail++;
         $display("FAIL seq_addr4: got ce=%b addr=%h v=%b ipc=%h inst=%h exp ce=1 addr=4 v=1 ipc=0 inst=%h", imem_ce, imem_addr, inst_valid, inst_pc, inst, mem_word(32'h0));
      end
      tick();
      n_checks++;
      if ({imem_ce, imem_addr, inst_valid, inst_pc, inst} !== {1'b1, 32'h8, 1'b1, 32'h4, mem_word(32'h4)}) begin
         n_fail++;
         $display("FAIL seq_addr8: got ce=%b addr=%h v=%b ipc=%h inst=%h exp ce=1 addr=8 v=1 ipc=4 inst=%h", imem_ce, imem_addr, inst_valid, inst_pc, inst, mem_word(32'h4));
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         stall = 1'b1;
         #1;
         n_checks++;
         if ({imem_ce, pc, inst_valid, inst_pc, inst} !== {1'b0, 32'h8, 1'b1, 32'h4, mem_word(32'h4)}) begin
            n_fail++;
            $display("FAIL stall_hold_%0d: got ce=%b pc=%h v=%b ipc=%h inst=%h exp ce=0 pc=8 v=1 ipc=4 inst=%h", i, imem_ce, pc, inst_valid, inst_pc, inst, mem_word(32'h4));
         end
      end
      tick();
`ifdef FETCH_PERF_CNT_EN
      n_checks++;
      if ({stall_count, fetch_count} !== {32'd4, 32'd2}) begin
         n_fail++;
         $display("FAIL stall_counters: got stall_count=%0d fetch_count=%0d exp 4 2", stall_count, fetch_count);
      end
`endif
   endtask

   task automatic test_mem_wait();
      stall = 1'b0; imem_ready = 1'b0;
      #1;
      n_checks++;
      if ({imem_ce, imem_addr, inst_valid} !== {1'b1, 32'h8, 1'b1}) begin
         n_fail++;
         $display("FAIL wait_c0: got ce=%b addr=%h v=%b exp ce=1 addr=8 v=1", imem_ce, imem_addr, inst_valid);
      end
      for (int i = 1; i < 3; i++) begin
         tick();
         n_checks++;
         if ({imem_ce, imem_addr, inst_valid} !== {1'b1, 32'h8, 1'b0}) begin
            n_fail++;
            $display("FAIL wait_c%0d: got ce=%b addr=%h v=%b exp ce=1 addr=8 v=0", i, imem_ce, imem_addr, inst_valid);
         end
      end
      tick();
      imem_ready = 1'b1;
      #1;
      n_checks++;
      if ({imem_ce, imem_addr, inst_valid} !== {1'b1, 32'h8, 1'b0}) begin
         n_fail++;
         $display("FAIL wait_ready: got ce=%b addr=%h v=%b exp ce=1 addr=8 v=0", imem_ce, imem_addr, inst_valid);
      end
      tick();
      n_checks++;
      if ({imem_addr, inst_valid, inst_pc, inst} !== {32'hC, 1'b1, 32'h8, mem_word(32'h8)}) begin
         n_fail++;
         $display("FAIL wait_resume: got addr=%h v=%b ipc=%h inst=%h exp addr=c v=1 ipc=8 inst=%h", imem_addr, inst_valid, inst_pc, inst, mem_word(32'h8));
      end
`ifdef FETCH_PERF_CNT_EN
      n_checks++;
      if (fetch_count !== 32'd3) begin
         n_fail++;
         $display("FAIL fetch_count: got %0d exp 3", fetch_count);
      end
`endif
   endtask

   task automatic test_redirect();
      stall = 1'b1; imem_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h100;
      #1;
      n_checks++;
      if ({imem_ce, inst_valid} !== {1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL redir_req: got ce=%b v=%b exp ce=0 v=1", imem_ce, inst_valid);
      end
      tick();
      redirect_valid = 1'b0; stall = 1'b0;
      #1;
      n_checks++;
      if ({dbg_state, imem_ce, inst_valid, pc} !== {S_BUBBLE, 1'b0, 1'b0, 32'h100}) begin
         n_fail++;
         $display("FAIL redir_bubble: got st=%0d ce=%b v=%b pc=%h exp st=2 ce=0 v=0 pc=100", dbg_state, imem_ce, inst_valid, pc);
      end
      tick();
      n_checks++;
      if ({dbg_state, imem_ce, imem_addr, inst_valid} !== {S_FETCH, 1'b1, 32'h100, 1'b0}) begin
         n_fail++;
         $display("FAIL redir_fetch: got st=%0d ce=%b addr=%h v=%b exp st=1 ce=1 addr=100 v=0", dbg_state, imem_ce, imem_addr, inst_valid);
      end
      tick();
      n_checks++;
      if ({inst_valid, inst_pc, inst, pc, misalign} !== {1'b1, 32'h100, mem_word(32'h100), 32'h104, 1'b0}) begin
         n_fail++;
         $display("FAIL redir_capture: got v=%b ipc=%h inst=%h pc=%h mis=%b exp v=1 ipc=100 inst=%h pc=104 mis=0", inst_valid, inst_pc, inst, pc, misalign, mem_word(32'h100));
      end
   endtask

   task automatic test_misalign();
      redirect_valid = 1'b1; redirect_target = 32'h203;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_checks++;
      if ({pc, misalign, inst_valid, dbg_state} !== {32'h200, 1'b1, 1'b0, S_BUBBLE}) begin
         n_fail++;
         $display("FAIL mis_set: got pc=%h mis=%b v=%b st=%0d exp pc=200 mis=1 v=0 st=2", pc, misalign, inst_valid, dbg_state);
      end
      tick();
      n_checks++;
      if ({imem_ce, imem_addr, misalign} !== {1'b1, 32'h200, 1'b1}) begin
         n_fail++;
         $display("FAIL mis_fetch: got ce=%b addr=%h mis=%b exp ce=1 addr=200 mis=1", imem_ce, imem_addr, misalign);
      end
      redirect_valid = 1'b1; redirect_target = 32'h300;
      tick();
      redirect_valid = 1'b0;
      #1;
      n_checks++;
      if ({pc, misalign} !== {32'h300, 1'b1}) begin
         n_fail++;
         $display("FAIL mis_sticky: got pc=%h mis=%b exp pc=300 mis=1", pc, misalign);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      redirect_valid = 1'b1; redirect_target = 32'h40;
      tick();
      redirect_valid = 1'b0;
      tick();
      imem_ready = 1'b0;
      #1;
      n_checks++;
      if ({imem_ce, imem_addr} !== {1'b1, 32'h40}) begin
         n_fail++;
         $display("FAIL rstmid_wait: got ce=%b addr=%h exp ce=1 addr=40", imem_ce, imem_addr);
      end
      tick();
      imem_ready = 1'b1; rst = 1'b1;
      #1;
      n_checks++;
      if (imem_ce !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_ce: got ce=%b exp ce=0", imem_ce);
      end
      tick();
      n_checks++;
      if ({dbg_state, pc, inst_valid, inst, inst_pc, misalign} !== {S_IDLE, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL rstmid_state: got st=%0d pc=%h v=%b inst=%h ipc=%h mis=%b exp all zero", dbg_state, pc, inst_valid, inst, inst_pc, misalign);
      end
`ifdef FETCH_PERF_CNT_EN
      n_checks++;
      if ({fetch_count, stall_count} !== 64'h0) begin
         n_fail++;
         $display("FAIL rstmid_counters: got fetch_count=%0d stall_count=%0d exp 0 0", fetch_count, stall_count);
      end
`endif
   endtask

   task automatic test_idle_redirect();
      rst = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h81;
      #1;
      n_checks++;
      if ({imem_ce, dbg_state} !== {1'b0, S_IDLE}) begin
         n_fail++;
         $display("FAIL idle_redir_ce: got ce=%b st=%0d exp ce=0 st=0", imem_ce, dbg_state);
      end
      tick();
      redirect_valid = 1'b0;
      #1;
      n_checks++;
      if ({dbg_state, pc, misalign, imem_ce, imem_addr} !== {S_FETCH, 32'h0, 1'b0, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL idle_redir_ignored: got st=%0d pc=%h mis=%b ce=%b addr=%h exp st=1 pc=0 mis=0 ce=1 addr=0", dbg_state, pc, misalign, imem_ce, imem_addr);
      end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      tick();
      n_checks++;
      if ({imem_ce, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
         n_fail++;
         $display("FAIL wrap_fetch: got ce=%b addr=%h exp ce=1 addr=fffffffc", imem_ce, imem_addr);
      end
      tick();
      n_checks++;
      if ({inst_valid, inst_pc, inst, pc, misalign} !== {1'b1, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC), 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL wrap_pc: got v=%b ipc=%h inst=%h pc=%h mis=%b exp v=1 ipc=fffffffc inst=%h pc=0 mis=0", inst_valid, inst_pc, inst, pc, misalign, mem_word(32'hFFFF_FFFC));
      end
      tick();
      n_checks++;
      if ({inst_pc, pc} !== {32'h0, 32'h4}) begin
         n_fail++;
         $display("FAIL wrap_next: got ipc=%h pc=%h exp ipc=0 pc=4", inst_pc, pc);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_mem_wait();
      test_redirect();
      test_misalign();
      test_reset_mid();
      test_idle_redirect();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
